// File: rtl/pal_timing_gen.sv
// Field/line timing generator and level multiplexer for a fake-progressive
// System I composite output. 312 lines of 128 ticks at a 2 MHz tick, with
// broad/short vertical sync half-lines and a registered 3-bit DAC code.
module pal_timing_gen #(
  parameter logic [2:0] SYNC_CODE   = 3'b011,
  parameter logic [2:0] BLACK_CODE  = 3'b110,
  parameter int         HSYNC_TICKS = 9,
  parameter int         ACT_START   = 20,
  parameter int         ACT_TICKS   = 104
) (
  input  logic       clk,
  input  logic       sys_rst_n,
  input  logic [2:0] pix_level,
  output logic       active,
  output logic [6:0] x,
  output logic [8:0] y,
  output logic       line_start,
  output logic       frame_start,
  output logic [2:0] sig
);

  localparam logic [6:0] HS_END  = 7'(HSYNC_TICKS);
  localparam logic [6:0] ACT_S   = 7'(ACT_START);
  localparam logic [6:0] ACT_E   = 7'(ACT_START + ACT_TICKS - 1);
  localparam logic [8:0] V_LAST  = 9'd311;
  localparam logic [8:0] V_ACT0  = 9'd23;

  typedef enum logic [2:0] {
    ST_BROAD,
    ST_SHORT_POST,
    ST_BLANK,
    ST_ACTIVE,
    ST_SHORT_PRE
  } field_t;

  logic [6:0] h;
  logic [8:0] v;
  field_t     state, state_nxt;
  logic [2:0] level;
  logic       broad_half, short_half, end_of_line;

  assign end_of_line = (h == 7'd127);

  // Horizontal tick and line counters; v steps on the last tick of each line.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h <= '0;
      v <= '0;
    end else begin
      h <= h + 7'd1;
      if (end_of_line) v <= (v == V_LAST) ? 9'd0 : v + 9'd1;
    end
  end

  // Field state register.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_BROAD;
    else            state <= state_nxt;
  end

  // Field transitions happen on the line boundary that leaves the last line
  // of each region, so the state always tracks the line about to start.
  always_comb begin
    state_nxt = state;
    if (end_of_line) begin
      case (state)
        ST_BROAD:      if (v == 9'd2)   state_nxt = ST_SHORT_POST;
        ST_SHORT_POST: if (v == 9'd4)   state_nxt = ST_BLANK;
        ST_BLANK:      if (v == 9'd22)  state_nxt = ST_ACTIVE;
        ST_ACTIVE:     if (v == 9'd308) state_nxt = ST_SHORT_PRE;
        ST_SHORT_PRE:  if (v == V_LAST) state_nxt = ST_BROAD;
        default:                        state_nxt = ST_BROAD;
      endcase
    end
  end

  // Half-line sync pulse shapes, position taken within the current half line.
  assign broad_half = (h[5:0] <= 6'd54);
  assign short_half = (h[5:0] <= 6'd4);

  // Active-video request decode, aligned with the counters.
  always_comb begin
    active = (state == ST_ACTIVE) && (h >= ACT_S) && (h <= ACT_E);
    x      = active ? (h - ACT_S)  : 7'd0;
    y      = active ? (v - V_ACT0) : 9'd0;
  end

  assign line_start  = (h == 7'd0);
  assign frame_start = (h == 7'd0) && (v == 9'd0);

  // Level for the current tick. Line 2 switches from broad to short pulses
  // at mid-line; upstream sync codes are replaced by black so the pattern
  // generator can never fake a sync edge.
  always_comb begin
    level = BLACK_CODE;
    case (state)
      ST_BROAD: begin
        if (h[6] && (v == 9'd2)) level = short_half ? SYNC_CODE : BLACK_CODE;
        else                     level = broad_half ? SYNC_CODE : BLACK_CODE;
      end
      ST_SHORT_POST, ST_SHORT_PRE:
        level = short_half ? SYNC_CODE : BLACK_CODE;
      default: begin
        if (h < HS_END)
          level = SYNC_CODE;
        else if (active)
          level = (pix_level == SYNC_CODE) ? BLACK_CODE : pix_level;
        else
          level = BLACK_CODE;
      end
    endcase
  end

  // Registered DAC output, one clock behind the counters.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) sig <= BLACK_CODE;
    else            sig <= level;
  end

endmodule
